keypad_entry: RTL
=================

# keypad_entry

Consumes the raw 5-bit key code from the keypad scanner and turns it into clean, single-shot key events. It accumulates up to four decimal digits, then commits them on `#` and checks the result against a configured arm code. Its outputs feed the video overlay (entered digits) and the blaster control logic (committed value, arm-code accept/reject). The block runs entirely in the 48 MHz system clock domain, the same as the scanner.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 48000: consecutive stable cycles required to accept a press or a release (1 ms at 48 MHz); legal range 2..2^20-1.
- `TIMEOUT_CYCLES`, default 480000000: idle cycles before a partial entry is discarded (10 s); legal range 2..2^32-1.
- `ARM_CODE`, default 16'h1234: 4-digit BCD arm code; the most significant nibble is the first digit entered.

Ports:
- `clk`, input, 1: system clock, 48 MHz.
- `reset_n`, input, 1: synchronous, active-low reset.
- `key`, input, 5: scanner code. 5'h10–5'h19 are digits 0–9, 5'h1A is `*`, 5'h1B is `#`, and 5'h00 means no key. Every other value is treated as no key.
- `key_event`, output, 1: one-cycle pulse for each accepted press.
- `key_code`, output, 4: `key[3:0]` of the last accepted press. Held between events.
- `digits`, output, 16: BCD entry; the newest digit is in `[3:0]`.
- `ndigits`, output, 3: number of digits entered, 0..4.
- `value`, output, 14: binary value of the entry, 0..9999.
- `commit`, output, 1: one-cycle pulse when `#` is accepted.
- `commit_value`, output, 14: `value` captured at commit. Held until the next commit.
- `code_ok`, output, 1: one-cycle pulse, coincident with `commit`, when the entry matches `ARM_CODE`.
- `code_bad`, output, 1: one-cycle pulse, coincident with `commit`, when the entry does not match.
- `timeout`, output, 1: one-cycle pulse when a partial entry is discarded.

## Operation
- The input is registered once as `key_q`. Any code that is not valid is mapped to 0 before debounce.
- A stability counter resets to 0 whenever `key_q` changes. Otherwise it increments, saturating at `DEBOUNCE_CYCLES`.
- The FSM has two states:
  - **IDLE**: when a nonzero `key_q` has been stable for `DEBOUNCE_CYCLES` cycles, issue one event and go to HELD.
  - **HELD**: stay until `key_q == 0` has been stable for `DEBOUNCE_CYCLES` cycles, then go to IDLE.
- Going directly from one key to another without a release produces no event. A stable zero is required first.
- Actions on an accepted event:
  - Digit d with `ndigits < 4`: `digits <= {digits[11:0], d}`, `value <= value*10 + d`, `ndigits` increments.
  - Digit with `ndigits == 4`: ignored, apart from `key_event` and `key_code`.
  - `*`: `digits`, `value` and `ndigits` clear to 0.
  - `#`: pulse `commit` and latch `commit_value <= value`. Pulse `code_ok` if `ndigits == 4 && digits == ARM_CODE`, otherwise pulse `code_bad`. Then clear the entry. `#` with an empty entry still commits 0 with `code_bad`.
- Value arithmetic is 14-bit unsigned. `value*10` is formed as `(value<<3) + (value<<1)` and cannot overflow because the entry is limited to 4 digits.
- Idle timeout:
  - A 32-bit counter resets on every `key_event`. It counts only while `ndigits > 0`.
  - When it reaches `TIMEOUT_CYCLES`, the entry clears and `timeout` pulses once. The counter then holds at 0 until the next digit.
  - If the timeout and an event fall in the same cycle, the event wins and the timeout is suppressed.

## Timing
- Reset values are 0 for every output, the FSM, both counters and `key_q`.
- Reset asserted mid-entry or mid-press clears everything on the next edge.
- A key held through reset release is debounced afresh and yields exactly one event.
- Event latency: with `key` presenting a valid code from cycle 0, `key_event` is high in cycle `DEBOUNCE_CYCLES + 1`.
  - `digits`, `value`, `ndigits`, `commit`, `code_ok`, `code_bad` and `commit_value` update in that same cycle. All outputs are registered.
- A glitch in `key` shorter than `DEBOUNCE_CYCLES` cycles produces no event and no state change.
- Maximum event rate is one event per `2*DEBOUNCE_CYCLES + 2` cycles.
- `commit` is exclusive with `timeout`. `code_ok` and `code_bad` are mutually exclusive and never assert without `commit`.

## Test plan
Run with `DEBOUNCE_CYCLES = 8`, `TIMEOUT_CYCLES = 200`, `ARM_CODE = 16'h1234`.
- **Reset, basic press:** reset, then hold `key` at 5'h15 for 20 cycles and release. Expect `key_event` for exactly 1 cycle at cycle 9, `key_code == 5`, `digits == 16'h0005`, `value == 5`, `ndigits == 1`.
- **Bounce rejection:** toggle `key` between 5'h13 and 0 every 3 cycles for 60 cycles, then hold 0. Expect no `key_event` and all outputs still 0.
- **Arm code accepted:** enter 1, 2, 3, 4, then `#`. Expect `digits == 16'h1234` and `value == 1234` before `#`. On `#`, expect `commit`, `code_ok`, `commit_value == 1234`, and the entry cleared.
- **Overflow, clear and reject:** enter 9, 8, 7, 6, 5. Expect `value == 9876` with 5 ignored. Then `*` clears to 0. Then enter 1, 2, 3, `#`: expect `commit_value == 123` with `code_bad`.
- **Timeout:** enter 7, then idle. Expect a single `timeout` pulse 200 cycles after that `key_event`, entry cleared, and no further pulse while empty.
- **Reset mid-press:** pulse `reset_n` low for 1 cycle while 5'h12 is held with `ndigits == 2`. Expect all outputs 0, then one new event giving `digits == 16'h0002`.

Source files
------------

// File: rtl/keypad_entry.sv
// keypad_entry: debounces raw keypad scanner codes into single-shot key events, collects up to
// four decimal digits, commits them on '#' and checks the entry against ARM_CODE.
//
// Ports:
//   clk           system clock (48 MHz)
//   reset_n       synchronous, active-low reset
//   key           scanner code: 5'h10..5'h19 digits 0..9, 5'h1A '*', 5'h1B '#', else no key
//   key_event     one-cycle pulse per accepted press
//   key_code      key[3:0] of the last accepted press
//   digits        BCD entry, newest digit in [3:0]
//   ndigits       number of digits entered (0..4)
//   value         binary value of the entry (0..9999)
//   commit        one-cycle pulse when '#' is accepted
//   commit_value  value captured at the last commit
//   code_ok       pulse with commit when the entry matches ARM_CODE
//   code_bad      pulse with commit when the entry does not match
//   timeout       one-cycle pulse when a partial entry is discarded for inactivity
module keypad_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 48000,
    parameter int unsigned TIMEOUT_CYCLES  = 480000000,
    parameter logic [15:0] ARM_CODE        = 16'h1234
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  key,
    output logic        key_event,
    output logic [3:0]  key_code,
    output logic [15:0] digits,
    output logic [2:0]  ndigits,
    output logic [13:0] value,
    output logic        commit,
    output logic [13:0] commit_value,
    output logic        code_ok,
    output logic        code_bad,
    output logic        timeout
);

    localparam logic [19:0] DebMax = 20'(DEBOUNCE_CYCLES);
    localparam logic [31:0] TmoMax = 32'(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {StIdle, StHeld} state_e;

    state_e      state_q, state_d;
    logic [4:0]  key_q, key_d;
    logic [19:0] cnt_q, cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic        key_event_q, key_event_d;
    logic [3:0]  key_code_q, key_code_d;
    logic [15:0] digits_q, digits_d;
    logic [2:0]  ndigits_q, ndigits_d;
    logic [13:0] value_q, value_d;
    logic        commit_q, commit_d;
    logic [13:0] commit_value_q, commit_value_d;
    logic        code_ok_q, code_ok_d;
    logic        code_bad_q, code_bad_d;
    logic        timeout_q, timeout_d;

    logic        stable;
    logic        fire;

    always_comb begin
        state_d        = state_q;
        tmo_d          = tmo_q;
        key_event_d    = 1'b0;
        key_code_d     = key_code_q;
        digits_d       = digits_q;
        ndigits_d      = ndigits_q;
        value_d        = value_q;
        commit_d       = 1'b0;
        commit_value_d = commit_value_q;
        code_ok_d      = 1'b0;
        code_bad_d     = 1'b0;
        timeout_d      = 1'b0;

        // Unrecognised scanner codes look exactly like "no key".
        key_d = (key >= 5'h10 && key <= 5'h1B) ? key : 5'h00;

        if (key_d != key_q) begin
            cnt_d = '0;
        end else if (cnt_q == DebMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 20'd1;
        end

        // Judged on the count being written this edge so the event lands one cycle after
        // key_q has held for DEBOUNCE_CYCLES cycles.
        stable = (cnt_d == DebMax);
        fire   = (state_q == StIdle) && stable && (key_q != 5'h00);

        unique case (state_q)
            StIdle: if (fire) state_d = StHeld;
            StHeld: if (stable && key_q == 5'h00) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (fire) begin
            key_event_d = 1'b1;
            key_code_d  = key_q[3:0];
            tmo_d       = '0;
            if (key_q[3:0] <= 4'd9) begin
                if (ndigits_q < 3'd4) begin
                    digits_d  = {digits_q[11:0], key_q[3:0]};
                    value_d   = (value_q << 3) + (value_q << 1) + {10'd0, key_q[3:0]};
                    ndigits_d = ndigits_q + 3'd1;
                end
            end else if (key_q[3:0] == 4'hA) begin
                digits_d  = '0;
                value_d   = '0;
                ndigits_d = '0;
            end else begin
                commit_d       = 1'b1;
                commit_value_d = value_q;
                if (ndigits_q == 3'd4 && digits_q == ARM_CODE) begin
                    code_ok_d = 1'b1;
                end else begin
                    code_bad_d = 1'b1;
                end
                digits_d  = '0;
                value_d   = '0;
                ndigits_d = '0;
            end
        end else if (ndigits_q != 3'd0) begin
            // An event in the same cycle takes the branch above, suppressing the timeout.
            if (tmo_q + 32'd1 == TmoMax) begin
                timeout_d = 1'b1;
                tmo_d     = '0;
                digits_d  = '0;
                value_d   = '0;
                ndigits_d = '0;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            key_q          <= '0;
            cnt_q          <= '0;
            tmo_q          <= '0;
            key_event_q    <= 1'b0;
            key_code_q     <= '0;
            digits_q       <= '0;
            ndigits_q      <= '0;
            value_q        <= '0;
            commit_q       <= 1'b0;
            commit_value_q <= '0;
            code_ok_q      <= 1'b0;
            code_bad_q     <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_q          <= key_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            key_event_q    <= key_event_d;
            key_code_q     <= key_code_d;
            digits_q       <= digits_d;
            ndigits_q      <= ndigits_d;
            value_q        <= value_d;
            commit_q       <= commit_d;
            commit_value_q <= commit_value_d;
            code_ok_q      <= code_ok_d;
            code_bad_q     <= code_bad_d;
            timeout_q      <= timeout_d;
        end
    end

    assign key_event    = key_event_q;
    assign key_code     = key_code_q;
    assign digits       = digits_q;
    assign ndigits      = ndigits_q;
    assign value        = value_q;
    assign commit       = commit_q;
    assign commit_value = commit_value_q;
    assign code_ok      = code_ok_q;
    assign code_bad     = code_bad_q;
    assign timeout      = timeout_q;

endmodule
